// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: state type and the
// status codes presented on the status port.
package stopwatch_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE      = 2'b00;
  localparam state_t ST_RUNNING   = 2'b01;
  localparam state_t ST_PAUSED    = 2'b10;
  localparam state_t ST_SATURATED = 2'b11;

endpackage

// File: rtl/tick_prescaler.sv
// One-second prescaler: counts 0..TICK_DIV-1 while enabled, holds when not,
// and flags the cycle in which it rolls over from TICK_DIV-1 back to 0.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic wrap
);

  localparam int unsigned W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] count;

  // Rollover is flagged in the cycle the counter sits at its last value, so
  // the controller can register its tick on the same edge the counter wraps.
  assign wrap = en && (count == LAST);

  // Counter: clear wins over enable; holds its phase while disabled.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of statement order.
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: detects rising edges on the user buttons, runs the
// IDLE/RUNNING/PAUSED/SATURATED state machine and issues one-cycle tick and
// clear pulses to the external count datapath. All outputs are registered.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       reset,
  input  logic       at_max,
  output logic       sec_tick,
  output logic       cnt_clr,
  output logic [1:0] status
);

  logic   start_q, stop_q, reset_q;
  logic   start_edge, stop_edge, reset_edge;
  logic   running, wrap;
  state_t state, state_next;

  // Button sampling. The samples keep tracking the inputs during rst, so a
  // button already held when rst releases has to fall and rise again before
  // it counts as a press.
  always_ff @(posedge clk) begin
    start_q <= start;
    stop_q  <= stop;
    reset_q <= reset;
  end

  assign start_edge = start & ~start_q;
  assign stop_edge  = stop  & ~stop_q;
  assign reset_edge = reset & ~reset_q;
  assign running    = (state == ST_RUNNING);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (running),
    .clr  (reset_edge),
    .wrap (wrap)
  );

  // Next-state logic. Only the highest-priority edge of a cycle is acted on
  // (reset > stop > start); a stop edge swallows a coincident start edge even
  // in states where stop itself is ignored.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    if (reset_edge) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_edge && !stop_edge) state_next = ST_RUNNING;
        end
        ST_RUNNING: begin
          if (stop_edge)            state_next = ST_PAUSED;
          else if (wrap && at_max)  state_next = ST_SATURATED;
        end
        ST_PAUSED: begin
          if (start_edge && !stop_edge) state_next = ST_RUNNING;
        end
        default: ;
      endcase
    end
  end

  // State and output pulses. A tick is only issued for a rollover that does
  // not coincide with a pause, a clear, or the count already at 99:59, which
  // also keeps sec_tick and cnt_clr mutually exclusive.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      sec_tick <= 1'b0;
      cnt_clr  <= 1'b0;
    end else begin
      state    <= state_next;
      sec_tick <= running && wrap && !at_max && !stop_edge && !reset_edge;
      cnt_clr  <= reset_edge;
    end
  end

  assign status = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with a one-second tick of four clocks: directed
// scenarios followed by random button traffic, all compared cycle by cycle
// against a behavioural model of the stopwatch.
module tb_stopwatch_ctrl;

  localparam int TICK_DIV = 4;

  logic       clk;
  logic       rst, start, stop, reset, at_max;
  logic       sec_tick, cnt_clr;
  logic [1:0] status;

  int total = 0;
  int bad   = 0;

  // Behavioural model: mode, running time in clocks since the last clear, and
  // the previous button levels.
  logic [1:0] m_status;
  logic       m_tick, m_clr;
  int         m_run;
  logic       p_start, p_stop, p_reset;

  stopwatch_ctrl #(
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .reset    (reset),
    .at_max   (at_max),
    .sec_tick (sec_tick),
    .cnt_clr  (cnt_clr),
    .status   (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of the stopwatch as a user sees it: the strongest new press
  // decides the action, and a full second of running time either advances the
  // display or, when the display is already at 99:59, freezes the watch.
  task automatic model_step();
    int  press;            // 3 clear, 2 pause, 1 start/resume, 0 none
    bit  second_done;
    if (rst) begin
      m_status = 2'b00;
      m_tick   = 1'b0;
      m_clr    = 1'b0;
      m_run    = 0;
    end else begin
      press = (reset && !p_reset) ? 3 :
              (stop  && !p_stop)  ? 2 :
              (start && !p_start) ? 1 : 0;
      second_done = (m_status == 2'b01) && (((m_run + 1) % TICK_DIV) == 0);
      m_tick = second_done && !at_max && press < 2;
      m_clr  = (press == 3);
      if (press == 3)              m_run = 0;
      else if (m_status == 2'b01)  m_run = m_run + 1;
      case (press)
        3: m_status = 2'b00;
        2: if (m_status == 2'b01) m_status = 2'b10;
        1: if (m_status == 2'b00 || m_status == 2'b10) m_status = 2'b01;
        default: ;
      endcase
      if (press < 2 && second_done && at_max) m_status = 2'b11;
    end
    p_start = start;
    p_stop  = stop;
    p_reset = reset;
  endtask

  task automatic step(input logic s, input logic p, input logic r,
                      input logic a, input logic x);
    @(negedge clk);
    start  = s;
    stop   = p;
    reset  = r;
    at_max = a;
    rst    = x;
    @(posedge clk);
    model_step();
    #1;
    chk("model status",   status,             m_status);
    chk("model sec_tick", {1'b0, sec_tick},   {1'b0, m_tick});
    chk("model cnt_clr",  {1'b0, cnt_clr},    {1'b0, m_clr});
  endtask

  initial begin
    start = 0; stop = 0; reset = 0; at_max = 0; rst = 1;
    m_status = 2'b00; m_tick = 0; m_clr = 0; m_run = 0;
    p_start = 0; p_stop = 0; p_reset = 0;

    // rst for two cycles, then a single start press
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("reset status",   status,           2'b00);
    chk("reset sec_tick", {1'b0, sec_tick}, 2'b00);
    chk("reset cnt_clr",  {1'b0, cnt_clr},  2'b00);
    step(1, 0, 0, 0, 0);
    chk("start status", status, 2'b01);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0, 0);
      chk("tick cadence", {1'b0, sec_tick}, {1'b0, (i % 4 == 3)});
    end

    // pause after two prescaler counts, resume five cycles later
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("pause status", status, 2'b10);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0);
      chk("paused status", status, 2'b10);
      chk("paused tick",   {1'b0, sec_tick}, 2'b00);
    end
    step(1, 0, 0, 0, 0);
    chk("resume status", status, 2'b01);
    step(0, 0, 0, 0, 0);
    chk("resume tick+1", {1'b0, sec_tick}, 2'b00);
    step(0, 0, 0, 0, 0);
    chk("resume tick+2", {1'b0, sec_tick}, 2'b01);

    // all three buttons together while running
    step(0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    chk("triple status",  status,           2'b00);
    chk("triple cnt_clr", {1'b0, cnt_clr},  2'b01);
    chk("triple tick",    {1'b0, sec_tick}, 2'b00);
    step(0, 0, 0, 0, 0);
    chk("triple clr once", {1'b0, cnt_clr}, 2'b00);

    // saturation at 99:59
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 0);
      chk("sat no tick", {1'b0, sec_tick}, 2'b00);
    end
    chk("sat status", status, 2'b11);
    step(1, 0, 0, 1, 0);
    chk("sat ignores start", status, 2'b11);
    step(0, 1, 0, 1, 0);
    chk("sat ignores stop", status, 2'b11);
    step(0, 0, 1, 1, 0);
    chk("sat clear status",  status,          2'b00);
    chk("sat clear cnt_clr", {1'b0, cnt_clr}, 2'b01);
    step(0, 0, 0, 0, 0);

    // held start gives one transition; rst mid-run aborts everything
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 0, 0);
      chk("held start status", status, 2'b01);
    end
    step(1, 0, 0, 0, 1);
    chk("rst status",   status,           2'b00);
    chk("rst sec_tick", {1'b0, sec_tick}, 2'b00);
    chk("rst cnt_clr",  {1'b0, cnt_clr},  2'b00);
    step(1, 0, 0, 0, 0);
    chk("held across rst", status, 2'b00);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0, 0);
      chk("post rst tick", {1'b0, sec_tick}, 2'b00);
      chk("post rst clr",  {1'b0, cnt_clr},  2'b00);
    end
    step(1, 0, 0, 0, 0);
    chk("restart status", status, 2'b01);

    // random button traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic s, p, r, a, x;
      s = ($urandom_range(7) < 2);
      p = ($urandom_range(15) == 0);
      r = ($urandom_range(31) == 0);
      a = ($urandom_range(7) == 0);
      x = ($urandom_range(127) == 0);
      step(s, p, r, a, x);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
